// File: rtl/x2050mpxq.sv
// Multiplexor channel buffer: DEPTH-entry FIFO shared between microcode MG orders
// and an autonomous service-in/service-out sequencer with tag timeout.
module x2050mpxq #(
  parameter int DEPTH = 4,
  parameter int DW    = 9,
  parameter int TMO   = 255
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_ros_advance,
  input  logic                       i_io_mode,
  input  logic [2:0]                 i_mg,
  input  logic                       i_dir_in,
  input  logic [DW-1:0]              i_buffer_out_bus,
  output logic [DW-1:0]              o_buffer_in_bus,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_full,
  output logic                       o_empty,
  output logic                       o_overrun,
  output logic                       o_underrun,
  output logic                       o_timeout,
  output logic                       o_status_seen,
  output logic [DW-1:0]              o_mpx_bus_out,
  input  logic [DW-1:0]              i_mpx_bus_in,
  output logic                       o_mpx_service_out,
  input  logic                       i_mpx_service_in,
  input  logic                       i_mpx_status_in,
  input  logic                       i_mpx_operational_in
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TMO + 1);
  localparam logic [1:0] S_IDLE = 2'd0, S_XFER = 2'd1, S_ACK = 2'd2;

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;
  logic          r_overrun, r_underrun, r_timeout, r_status_seen;
  logic [1:0]    r_state;
  logic [TW-1:0] r_tmo;
  logic          r_so, r_si_q, r_st_q;
  logic [DW-1:0] r_bus_out;

  logic          w_g, w_cpu_clr, w_cpu_pop, w_cpu_push;
  logic          w_full, w_empty, w_si_rise, w_st_rise, w_abort;
  logic          w_seq_push, w_seq_pop, w_push, w_pop, w_push_ok, w_pop_ok;
  logic [DW-1:0] w_push_data, w_head;

  assign w_g        = i_ros_advance & i_io_mode & ~i_reset;
  assign w_cpu_clr  = w_g & (i_mg == 3'd1);
  assign w_cpu_pop  = w_g & (i_mg == 3'd3);
  assign w_cpu_push = w_g & (i_mg == 3'd4);

  assign w_full    = (r_count == CW'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_head    = r_mem[r_rptr];
  assign w_si_rise = i_mpx_service_in & ~r_si_q;
  assign w_st_rise = i_mpx_status_in & ~r_st_q;
  // Any condition that kicks the sequencer back to IDLE also suppresses its transfer.
  assign w_abort   = ~i_mpx_operational_in | (w_st_rise & (r_state != S_IDLE));

  // CPU has priority on a same-kind collision; the sequencer simply retries.
  assign w_seq_push = (r_state == S_XFER) & i_dir_in & ~w_full & ~w_cpu_push
                    & ~w_cpu_clr & ~w_abort;
  assign w_seq_pop  = (r_state == S_XFER) & ~i_dir_in & ~w_empty & ~w_cpu_pop
                    & ~w_cpu_clr & ~w_abort;

  assign w_push      = w_cpu_push | w_seq_push;
  assign w_pop       = w_cpu_pop | w_seq_pop;
  assign w_push_data = w_cpu_push ? i_buffer_out_bus : i_mpx_bus_in;
  assign w_pop_ok    = w_pop & ~w_empty;
  assign w_push_ok   = w_push & (~w_full | w_pop_ok);

  assign o_buffer_in_bus   = (w_cpu_pop & ~w_empty) ? w_head : '0;
  assign o_count           = r_count;
  assign o_full            = w_full;
  assign o_empty           = w_empty;
  assign o_overrun         = r_overrun;
  assign o_underrun        = r_underrun;
  assign o_timeout         = r_timeout;
  assign o_status_seen     = r_status_seen;
  assign o_mpx_bus_out     = r_bus_out;
  assign o_mpx_service_out = r_so;

  always_ff @(posedge i_clk) begin
    if (w_push_ok) r_mem[r_wptr] <= w_push_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset || w_cpu_clr) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overrun  <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + AW'(1);
      if (w_pop_ok)  r_rptr <= r_rptr + AW'(1);
      if (w_push_ok && !w_pop_ok)      r_count <= r_count + CW'(1);
      else if (!w_push_ok && w_pop_ok) r_count <= r_count - CW'(1);
      if (w_push && !w_push_ok) r_overrun  <= 1'b1;
      if (w_cpu_pop && w_empty) r_underrun <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= S_IDLE;
      r_tmo         <= '0;
      r_so          <= 1'b0;
      r_si_q        <= 1'b0;
      r_st_q        <= 1'b0;
      r_bus_out     <= '0;
      r_timeout     <= 1'b0;
      r_status_seen <= 1'b0;
    end else begin
      r_si_q <= i_mpx_service_in;
      r_st_q <= i_mpx_status_in;
      if (w_cpu_clr) begin
        r_timeout     <= 1'b0;
        r_status_seen <= 1'b0;
      end
      // Latch lingers one cycle after service-out falls, then clears.
      if (!r_so) r_bus_out <= '0;

      if (!i_mpx_operational_in) begin
        r_state   <= S_IDLE;
        r_so      <= 1'b0;
        r_tmo     <= '0;
        r_bus_out <= '0;
      end else if (w_st_rise && r_state != S_IDLE) begin
        r_status_seen <= 1'b1;
        r_state       <= S_IDLE;
        r_so          <= 1'b0;
        r_tmo         <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_si_rise) begin
              r_state <= S_XFER;
              r_tmo   <= '0;
            end
          end
          S_XFER, S_ACK: begin
            if (w_seq_push || w_seq_pop) begin
              if (w_seq_pop) r_bus_out <= w_head;
              r_so    <= 1'b1;
              r_state <= S_ACK;
              r_tmo   <= '0;
            end else if (r_state == S_ACK && !i_mpx_service_in) begin
              r_so    <= 1'b0;
              r_state <= S_IDLE;
              r_tmo   <= '0;
            end else if (r_tmo == TW'(TMO - 1)) begin
              r_timeout <= 1'b1;
              r_so      <= 1'b0;
              r_state   <= S_IDLE;
              r_tmo     <= '0;
            end else begin
              r_tmo <= r_tmo + TW'(1);
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_so    <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_x2050mpxq.sv
// Randomized scoreboard bench: a queue model of the FIFO predicts CPU pops and bus-out bytes.
module tb_x2050mpxq;
  localparam int DEPTH = 4;
  localparam int DW    = 9;
  localparam int TMO   = 16;

  logic          clk = 1'b0;
  logic          rst, ros, iom, dir, si, st, opin;
  logic [2:0]    mg;
  logic [DW-1:0] bob, bus_in, bib, bus_out;
  logic [2:0]    cnt;
  logic          full, empty, ovr, unr, tmo, sts, so;

  int n_tests = 0;
  int n_fail  = 0;
  logic [DW-1:0] mdl[$];
  logic [DW-1:0] exp_pop[$];
  logic [DW-1:0] exp_bus[$];
  logic          so_prev = 1'b0;

  always #5 clk = ~clk;

  x2050mpxq #(.DEPTH(DEPTH), .DW(DW), .TMO(TMO)) dut (
    .i_clk(clk), .i_reset(rst), .i_ros_advance(ros), .i_io_mode(iom), .i_mg(mg),
    .i_dir_in(dir), .i_buffer_out_bus(bob), .o_buffer_in_bus(bib), .o_count(cnt),
    .o_full(full), .o_empty(empty), .o_overrun(ovr), .o_underrun(unr),
    .o_timeout(tmo), .o_status_seen(sts), .o_mpx_bus_out(bus_out),
    .i_mpx_bus_in(bus_in), .o_mpx_service_out(so), .i_mpx_service_in(si),
    .i_mpx_status_in(st), .i_mpx_operational_in(opin));

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: CPU pop data and bus-out byte at each write-direction service-out rise.
  always @(negedge clk) begin
    if (ros && iom && mg == 3'd3) begin
      if (exp_pop.size() == 0) check("pop_unexpected", 1, 0);
      else check("pop_data", bib, exp_pop.pop_front());
    end
    if (so && !so_prev && !dir) begin
      if (exp_bus.size() == 0) check("busout_unexpected", 1, 0);
      else check("busout_data", bus_out, exp_bus.pop_front());
    end
    so_prev = so;
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic cpu_op(input logic [2:0] m, input logic [DW-1:0] d);
    ros = 1'b1; mg = m; bob = d;
    tick();
    ros = 1'b0; mg = 3'd0;
  endtask

  task automatic cpu_push(input logic [DW-1:0] v);
    if (mdl.size() < DEPTH) mdl.push_back(v);
    cpu_op(3'd4, v);
  endtask

  task automatic cpu_pop();
    exp_pop.push_back(mdl.size() > 0 ? mdl.pop_front() : '0);
    cpu_op(3'd3, '0);
  endtask

  task automatic cpu_clr();
    mdl.delete();
    cpu_op(3'd1, '0);
  endtask

  task automatic wait_so(input logic lvl, input string nm);
    int k = 0;
    while (so !== lvl && k < 10) begin tick(); k++; end
    if (so !== lvl) check(nm, so, lvl);
  endtask

  task automatic dev_read(input logic [DW-1:0] v);
    dir = 1'b1; bus_in = v; si = 1'b1;
    wait_so(1'b1, "rd_so_rise");
    mdl.push_back(v);
    si = 1'b0;
    wait_so(1'b0, "rd_so_fall");
    tick();
  endtask

  task automatic dev_write();
    dir = 1'b0; exp_bus.push_back(mdl.pop_front()); si = 1'b1;
    wait_so(1'b1, "wr_so_rise");
    si = 1'b0;
    wait_so(1'b0, "wr_so_fall");
    tick(2);
    check("wr_busout_clr", bus_out, 0);
  endtask

  initial begin
    logic saw_so;
    rst = 1'b1; ros = 0; iom = 1; mg = 0; dir = 0; si = 0; st = 0; opin = 1;
    bob = '0; bus_in = '0;
    tick(3);
    check("rst_count", cnt, 0);
    check("rst_empty", empty, 1);
    check("rst_flags", {full, ovr, unr, tmo, sts, so}, 0);
    check("rst_buses", {bib, bus_out}, 0);
    rst = 1'b0;
    tick();

    // Fill, overrun, drain, underrun.
    cpu_push(9'h101); cpu_push(9'h002); cpu_push(9'h003); cpu_push(9'h104);
    check("fill_count", cnt, 4);
    check("fill_full", full, 1);
    cpu_push(9'h1FF);
    check("overrun", ovr, 1);
    check("overrun_count", cnt, 4);
    repeat (4) cpu_pop();
    check("drain_empty", empty, 1);
    cpu_pop();
    check("underrun", unr, 1);
    cpu_clr();
    check("clr_flags", {ovr, unr}, 0);

    // Write direction with exact latency.
    cpu_push(9'h0A5);
    dir = 1'b0; exp_bus.push_back(mdl.pop_front()); si = 1'b1;
    tick();
    check("wr_lat1_so", so, 0);
    tick();
    check("wr_lat2_so", so, 1);
    check("wr_busout", bus_out, 9'h0A5);
    si = 1'b0;
    tick();
    check("wr_so_drop", so, 0);
    check("wr_bus_hold", bus_out, 9'h0A5);
    tick();
    check("wr_bus_clr", bus_out, 0);
    check("wr_count", cnt, 0);

    // Read direction into empty FIFO.
    dev_read(9'h011); dev_read(9'h122); dev_read(9'h033);
    check("rd_count", cnt, 3);
    repeat (3) cpu_pop();

    // Randomized mix.
    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 3))
        0: cpu_push(DW'($urandom_range(0, 511)));
        1: cpu_pop();
        2: if (mdl.size() < DEPTH) dev_read(DW'($urandom_range(0, 511))); else cpu_pop();
        default: if (mdl.size() > 0) dev_write(); else cpu_push(DW'($urandom_range(0, 511)));
      endcase
      check("rand_count", cnt, mdl.size());
    end

    // Timeout on a full FIFO.
    cpu_clr();
    repeat (4) cpu_push(DW'($urandom_range(0, 511)));
    dir = 1'b1; si = 1'b1; saw_so = 1'b0;
    for (int k = 0; k < TMO + 6 && !tmo; k++) begin
      tick();
      if (so) saw_so = 1'b1;
    end
    check("tmo_set", tmo, 1);
    check("tmo_no_so", saw_so, 0);
    si = 1'b0;
    tick();
    cpu_clr();
    check("tmo_clr", tmo, 0);
    check("tmo_clr_count", cnt, 0);

    // Status-in during ACK.
    cpu_push(9'h1C3);
    dir = 1'b0; exp_bus.push_back(mdl.pop_front()); si = 1'b1;
    wait_so(1'b1, "st_so_rise");
    st = 1'b1;
    tick();
    check("st_so_drop", so, 0);
    check("st_seen", sts, 1);
    st = 1'b0; si = 1'b0;
    tick(3);
    check("st_bus_clr", bus_out, 0);
    cpu_clr();
    check("st_clr", sts, 0);

    // Operational-in drop during XFER (full, read direction holding).
    repeat (4) cpu_push(DW'($urandom_range(0, 511)));
    dir = 1'b1; si = 1'b1;
    tick(2);
    opin = 1'b0;
    tick();
    check("op_xfer_so", so, 0);
    check("op_xfer_count", cnt, 4);
    opin = 1'b1; si = 1'b0;
    tick(2);

    // Operational-in drop during ACK clears a loaded bus-out at once.
    dir = 1'b0; exp_bus.push_back(mdl.pop_front()); si = 1'b1;
    wait_so(1'b1, "op_ack_rise");
    opin = 1'b0;
    tick();
    check("op_ack_so", so, 0);
    check("op_ack_bus", bus_out, 0);
    check("op_ack_count", cnt, 3);
    opin = 1'b1; si = 1'b0;
    tick(2);

    // CPU pop and sequencer push in the same cycle.
    cpu_clr();
    cpu_push(9'h0AA); cpu_push(9'h0BB);
    dir = 1'b1; bus_in = 9'h155; si = 1'b1;
    tick();
    ros = 1'b1; mg = 3'd3;
    exp_pop.push_back(mdl.pop_front());
    mdl.push_back(9'h155);
    tick();
    ros = 1'b0; mg = 3'd0;
    check("sim_count", cnt, 2);
    check("sim_so", so, 1);
    si = 1'b0;
    wait_so(1'b0, "sim_so_fall");
    tick();
    cpu_pop(); cpu_pop();
    check("sim_empty", empty, 1);

    tick(2);
    check("sb_pop_drained", exp_pop.size(), 0);
    check("sb_bus_drained", exp_bus.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
